// File: rtl/mx_pkg.sv
// Shared constants and helpers for the arbitrating multiplexer.
package mx_pkg;

   // Mode selection for mx_arb_rr
   localparam int MX_MODE_RR  = 0;   // round-robin arbitration
   localparam int MX_MODE_SEL = 1;   // explicit select via i_sel

   // Ceiling log2 with a floor of 1, so a 2-channel mux still gets a 1-bit index.
   function automatic int mx_clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      if (r < 1) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/mx_arb_rr_if.sv
// Bundle of the producer-side and consumer-side handshake signals of mx_arb_rr.
//
// Handshake: a word moves across a channel in any cycle where valid and ready
// are both high at the rising edge. Producers raise i_valid[k] with stable
// i_data slice k and hold both until o_ready[k] is seen with it. On the output,
// o_valid/o_data/o_ch stay stable until the consumer samples i_ready high.
interface mx_arb_rr_if
   import mx_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NCH   = 4,
   parameter int SELW  = mx_clog2(NCH)
);

   logic [NCH-1:0]       i_valid;
   logic [NCH*WIDTH-1:0] i_data;
   logic [NCH-1:0]       o_ready;
   logic [SELW-1:0]      i_sel;
   logic                 o_valid;
   logic [WIDTH-1:0]     o_data;
   logic [SELW-1:0]      o_ch;
   logic                 i_ready;

   // Arbiter side
   modport slave (
      input  i_valid, i_data, i_sel, i_ready,
      output o_ready, o_valid, o_data, o_ch
   );

   // Producer/consumer side
   modport master (
      output i_valid, i_data, i_sel, i_ready,
      input  o_ready, o_valid, o_data, o_ch
   );

endinterface

// File: rtl/rr_grant.sv
// Round-robin grant: first requester found searching cyclically from ptr+1.
// The cyclic walk is the rotate / priority-find / un-rotate done in one loop.
module rr_grant
   import mx_pkg::*;
#(
   parameter int NCH  = 4,
   parameter int SELW = mx_clog2(NCH)
) (
   input  logic [NCH-1:0]  req,
   input  logic [SELW-1:0] ptr,
   output logic [NCH-1:0]  gnt,
   output logic [SELW-1:0] idx
);

   // Walk channels ptr+1, ptr+2, ... (mod NCH) and grant the first requester
   always_comb begin
      int  k;
      logic found;
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      k     = 0;
      for (int off = 1; off <= NCH; off++) begin
         k = int'(ptr) + off;
         if (k >= NCH) k = k - NCH;
         if (!found && req[k]) begin
            found  = 1'b1;
            gnt[k] = 1'b1;
            idx    = SELW'(k);
         end
      end
   end

endmodule

// File: rtl/mx_arb_rr.sv
// N-channel arbitrating multiplexer with one registered output stage.
// MODE 0 picks channels round-robin; MODE 1 follows i_sel like a plain mux.
module mx_arb_rr
   import mx_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NCH   = 4,
   parameter int MODE  = MX_MODE_RR
) (
   input logic         clk,
   input logic         reset_n,
   mx_arb_rr_if.slave  bus
);

   localparam int SELW = mx_clog2(NCH);

   logic             accept;
   logic             xfer_in;
   logic [NCH-1:0]   grant_raw;
   logic [NCH-1:0]   grant;
   logic [NCH-1:0]   ready;
   logic [SELW-1:0]  grant_idx;
   logic [WIDTH-1:0] data_mux;
   logic             valid_q;
   logic [WIDTH-1:0] data_q;
   logic [SELW-1:0]  ch_q;

   generate
      if (MODE == MX_MODE_RR) begin : g_rr
         logic [SELW-1:0] ptr;
         logic            unused_sel;

         assign unused_sel = ^bus.i_sel;

         rr_grant #(
            .NCH  (NCH),
            .SELW (SELW)
         ) u_grant (
            .req (bus.i_valid),
            .ptr (ptr),
            .gnt (grant_raw),
            .idx (grant_idx)
         );

         // Last-granted channel; reset to NCH-1 so channel 0 wins first
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)     ptr <= SELW'(NCH - 1);
            else if (xfer_in) ptr <= grant_idx;
         end
      end else begin : g_sel
         // Explicit select; out-of-range i_sel grants nothing
         always_comb begin
            grant_raw = '0;
            if (int'(bus.i_sel) < NCH) grant_raw[bus.i_sel] = bus.i_valid[bus.i_sel];
         end
         assign grant_idx = bus.i_sel;
      end
   endgenerate

   // Grant is suppressed while reset is held so o_ready cannot rise during reset
   assign grant   = reset_n ? grant_raw : '0;
   assign accept  = !valid_q || bus.i_ready;
   assign ready   = accept ? grant : '0;
   assign xfer_in = |(ready & bus.i_valid);

   // AND-OR select of the granted channel slice
   always_comb begin
      data_mux = '0;
      for (int k = 0; k < NCH; k++) begin
         data_mux = data_mux | (bus.i_data[k*WIDTH +: WIDTH] & {WIDTH{grant[k]}});
      end
   end

   // Output stage: load on transfer in, clear valid on a drain with no reload
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         ch_q    <= '0;
      end else if (xfer_in) begin
         valid_q <= 1'b1;
         data_q  <= data_mux;
         ch_q    <= grant_idx;
      end else if (valid_q && bus.i_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign bus.o_ready = ready;
   assign bus.o_valid = valid_q;
   assign bus.o_data  = data_q;
   assign bus.o_ch    = ch_q;

endmodule

// File: tb/tb_mx_arb_rr.sv
// Directed bench for mx_arb_rr: round-robin DUT with a word scoreboard, plus
// two explicit-select DUTs (4 and 3 channels) checked directly.
module tb_mx_arb_rr;
   import mx_pkg::*;

   logic clk;
   logic reset_n;

   int n_tests = 0;
   int n_fail  = 0;
   logic [33:0] exp_q[$];
   logic [33:0] exp_w;

   mx_arb_rr_if #(.WIDTH(32), .NCH(4)) ia ();
   mx_arb_rr_if #(.WIDTH(32), .NCH(4)) ib ();
   mx_arb_rr_if #(.WIDTH(32), .NCH(3)) ic ();

   mx_arb_rr #(.WIDTH(32), .NCH(4), .MODE(MX_MODE_RR)) dut_a (
      .clk (clk), .reset_n (reset_n), .bus (ia.slave));
   mx_arb_rr #(.WIDTH(32), .NCH(4), .MODE(MX_MODE_SEL)) dut_b (
      .clk (clk), .reset_n (reset_n), .bus (ib.slave));
   mx_arb_rr #(.WIDTH(32), .NCH(3), .MODE(MX_MODE_SEL)) dut_c (
      .clk (clk), .reset_n (reset_n), .bus (ic.slave));

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   function automatic logic [33:0] mk(input int ch, input logic [31:0] base);
      return {2'(ch), base | 32'(ch)};
   endfunction

   task automatic set_data_a(input logic [31:0] base);
      for (int k = 0; k < 4; k++) ia.i_data[k*32 +: 32] = base | 32'(k);
   endtask

   // scoreboard: every word leaving DUT A must match the head of exp_q
   always @(negedge clk) begin
      if (reset_n && ia.o_valid && ia.i_ready) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected", {ia.o_ch, ia.o_data}, 64'hdead);
         end else begin
            exp_w = exp_q.pop_front();
            chk("sb_word", {ia.o_ch, ia.o_data}, exp_w);
         end
      end
   end

   logic [3:0] sp_mask [7];
   int         sp_ch   [7];

   initial begin
      sp_mask = '{4'b0010, 4'b1010, 4'b1010, 4'b1110, 4'b1010, 4'b0011, 4'b0011};
      sp_ch   = '{1, 3, 1, 2, 3, 0, 1};

      reset_n = 1'b1;
      ia.i_valid = 4'b1111; ia.i_ready = 1'b1; ia.i_sel = '0; set_data_a(32'hA000_0000);
      ib.i_valid = '0; ib.i_ready = 1'b1; ib.i_sel = '0;
      for (int k = 0; k < 4; k++) ib.i_data[k*32 +: 32] = 32'hD000_0000 | 32'(k);
      ic.i_valid = '0; ic.i_ready = 1'b1; ic.i_sel = '0;
      for (int k = 0; k < 3; k++) ic.i_data[k*32 +: 32] = 32'hE000_0000 | 32'(k);
      #1 reset_n = 1'b0;
      #1;

      // reset state with every channel requesting
      chk("rst_o_valid", ia.o_valid, 0);
      chk("rst_o_data",  ia.o_data,  0);
      chk("rst_o_ch",    ia.o_ch,    0);
      chk("rst_o_ready", ia.o_ready, 0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      // round-robin over all-requesting channels: 0,1,2,3,0,... no bubbles
      for (int i = 0; i < 8; i++) begin
         settle();
         chk("rr_o_ready", ia.o_ready, 4'b0001 << (i % 4));
         if (i > 0) chk("rr_no_bubble", ia.o_valid, 1);
         exp_q.push_back(mk(i % 4, 32'hA000_0000));
         tick();
      end
      ia.i_valid = '0;
      tick();
      chk("rr_drained", ia.o_valid, 0);

      // sparse requests, pointer starts at 3
      set_data_a(32'hB000_0000);
      for (int s = 0; s < 7; s++) begin
         ia.i_valid = sp_mask[s];
         settle();
         chk("sparse_o_ready", ia.o_ready, 4'b0001 << sp_ch[s]);
         exp_q.push_back(mk(sp_ch[s], 32'hB000_0000));
         tick();
      end
      ia.i_valid = '0;
      tick();
      chk("sparse_drained", ia.o_valid, 0);

      // backpressure: pointer is 1, so channel 2 goes first
      set_data_a(32'hC000_0000);
      ia.i_valid = 4'b1111;
      settle();
      chk("bp_first_ready", ia.o_ready, 4'b0100);
      exp_q.push_back(mk(2, 32'hC000_0000));
      tick();
      ia.i_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         settle();
         chk("bp_o_ready", ia.o_ready, 0);
         chk("bp_o_valid", ia.o_valid, 1);
         chk("bp_o_data",  ia.o_data,  32'hC000_0002);
         chk("bp_o_ch",    ia.o_ch,    2);
         tick();
      end
      ia.i_ready = 1'b1;
      settle();
      chk("bp_resume_ready", ia.o_ready, 4'b1000);
      exp_q.push_back(mk(3, 32'hC000_0000));
      tick();
      settle();
      chk("bp_no_bubble", ia.o_valid, 1);
      chk("bp_next_ready", ia.o_ready, 4'b0001);
      exp_q.push_back(mk(0, 32'hC000_0000));
      tick();
      ia.i_valid = '0;
      tick();
      chk("bp_drained", ia.o_valid, 0);

      // async reset during a stall (pointer 1 before reset)
      ia.i_valid = 4'b0010;
      settle();
      exp_q.push_back(mk(1, 32'hC000_0000));
      tick();
      ia.i_ready = 1'b0;
      ia.i_valid = 4'b1111;
      settle();
      chk("stall_o_ready", ia.o_ready, 0);
      #1 reset_n = 1'b0;
      #1;
      chk("arst_o_valid", ia.o_valid, 0);
      chk("arst_o_data",  ia.o_data,  0);
      chk("arst_o_ch",    ia.o_ch,    0);
      chk("arst_o_ready", ia.o_ready, 0);
      void'(exp_q.pop_back());  // pending word is discarded by reset
      tick();
      reset_n = 1'b1;
      settle();
      chk("arst_ptr_reset", ia.o_ready, 4'b0001);
      ia.i_valid = '0;
      ia.i_ready = 1'b1;
      tick();
      tick();

      // explicit select, 4 channels
      ib.i_sel = 2'd2; ib.i_valid = 4'b0110;
      settle();
      chk("sel_o_ready", ib.o_ready, 4'b0100);
      tick();
      chk("sel_o_valid", ib.o_valid, 1);
      chk("sel_o_ch",    ib.o_ch,    2);
      chk("sel_o_data",  ib.o_data,  32'hD000_0002);
      ib.i_sel = 2'd1; ib.i_valid = 4'b0100;
      settle();
      chk("sel_idle_ready", ib.o_ready, 0);
      tick();
      chk("sel_idle_valid", ib.o_valid, 0);
      ib.i_sel = 2'd3; ib.i_valid = 4'b1000;
      settle();
      chk("sel_top_ready", ib.o_ready, 4'b1000);
      tick();
      chk("sel_top_ch",   ib.o_ch,   3);
      chk("sel_top_data", ib.o_data, 32'hD000_0003);
      ib.i_valid = '0;

      // explicit select, 3 channels, out-of-range index
      ic.i_sel = 2'd3; ic.i_valid = 3'b111;
      settle();
      chk("sel3_oor_ready", ic.o_ready, 0);
      tick();
      chk("sel3_oor_valid", ic.o_valid, 0);
      ic.i_sel = 2'd2;
      settle();
      chk("sel3_ready", ic.o_ready, 3'b100);
      tick();
      chk("sel3_o_valid", ic.o_valid, 1);
      chk("sel3_o_ch",    ic.o_ch,    2);
      chk("sel3_o_data",  ic.o_data,  32'hE000_0002);
      ic.i_valid = '0;
      tick();

      chk("sb_leftover", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
